cmem_responder: RTL and testbench
=================================

Name: cmem_responder

Overview:
- Memory-side responder for the CPU's two cmem initiator ports: port a (instruction fetch) and port b (data load/store).
- Serializes both ports onto one physical memory interface (pmem) with a multi-cycle handshake.
- The CPU pipeline advances only in a cycle where every requesting port sees resp. The block therefore buffers completed results and returns them to all requesting ports in the same cycle.

Parameters:
- PERF_WIDTH, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmem_read_a  in  1  port a read request; held until cmem_resp_a.
- cmem_write_a  in  1  port a write request (CPU ties 0; supported anyway).
- cmem_byte_enable_a  in  4  port a byte enables.
- cmem_address_a  in  32  port a address.
- cmem_wdata_a  in  32  port a write data.
- cmem_resp_a  out  1  port a one-cycle completion pulse.
- cmem_rdata_a  out  32  port a read data; valid while cmem_resp_a=1.
- cmem_read_b, cmem_write_b, cmem_byte_enable_b, cmem_address_b, cmem_wdata_b  in  1/1/4/32/32  port b request, same rules as port a.
- cmem_resp_b  out  1  port b completion pulse.
- cmem_rdata_b  out  32  port b read data.
- pmem_read  out  1  downstream read strobe; held until pmem_resp.
- pmem_write  out  1  downstream write strobe; held until pmem_resp.
- pmem_byte_enable  out  4  downstream byte enables.
- pmem_address  out  32  downstream address.
- pmem_wdata  out  32  downstream write data.
- pmem_resp  in  1  downstream completion, one cycle.
- pmem_rdata  in  32  downstream read data; valid with pmem_resp.
- perf_a_count  out  PERF_WIDTH  completed port a transactions (optional feature).
- perf_b_count  out  PERF_WIDTH  completed port b transactions (optional feature).

Behaviour:
- Request definition: req_x = cmem_read_x | cmem_write_x.
  - If read and write are both high on a port, it is treated as a write.
- FSM states: IDLE, SERVE_B, SERVE_A, RESP.
- IDLE:
  - If neither req_a nor req_b is high, remain in IDLE.
  - Otherwise latch the pending mask {req_a, req_b} and all request fields of both ports into capture registers.
  - Next state is SERVE_B if req_b, else SERVE_A.
- SERVE_B:
  - Drive pmem_* from the captured port b fields.
  - On pmem_resp, buffer rdata_b: pmem_rdata for a read, 32'h0 for a write.
  - Next state is SERVE_A if the mask includes a, else RESP.
- SERVE_A: same as SERVE_B using port a fields; on pmem_resp, next state is RESP.
- Data port is always served first, so priority is fixed b-before-a.
- Back-to-back: SERVE_B to SERVE_A keeps the strobe high with no gap. The pmem_* fields change on the edge after pmem_resp.
- RESP:
  - Assert cmem_resp_x for exactly one cycle, for every port in the mask, simultaneously.
  - cmem_rdata_x is driven from its buffer.
  - Next state is IDLE unconditionally. The one IDLE cycle lets the CPU update its requests after resp before they are resampled.
- Latency, single port, pmem_resp in first serve cycle: request at cycle 0, pmem strobe at cycle 1, cmem_resp at cycle 2.
- Latency, both ports, 1-cycle memory: cmem_resp_a and cmem_resp_b both at cycle 3.
- Request changes while not in IDLE are ignored; captured values are used.
- pmem_rdata is sampled only in cycles where pmem_resp=1 in a SERVE state. pmem_resp in IDLE or RESP is ignored.
- Outputs are registered or decoded from state only, with no combinational path from cmem inputs to pmem outputs.
- Reset (async, any time including mid-transaction):
  - State returns to IDLE; mask, capture and buffer registers clear to 0.
  - All outputs are 0, including cmem_resp_*, cmem_rdata_*, pmem_* and the counters.
  - Any in-flight pmem transaction is abandoned; a late pmem_resp after reset is ignored.

Optional Feature:
- Macro: CMEM_RESPONDER_PERF_EN.
- Defined: perf_a_count and perf_b_count increment by 1 in each RESP cycle in which the respective resp is asserted. They wrap modulo 2^PERF_WIDTH and are cleared by reset.
- Undefined: both counter outputs are tied to 0 and no counter flops exist.

Test Plan:
- Port a read only, addr 32'h0000_0060, pmem returns 32'h0000_0013 one cycle after the strobe -> pmem_read high for 1 cycle with address 0x60; cmem_resp_a=1 with rdata 0x13 for exactly one cycle; cmem_resp_b stays 0.
- Both ports active: a read at 0x60, b read at 0x100, pmem latency 3 per access -> pmem serves 0x100 then 0x60 with no strobe gap; cmem_resp_a and cmem_resp_b assert in the same cycle with their respective data.
- Port a read plus port b write (0x200, wdata 0xDEADBEEF, be 4'b0011) -> pmem_write carries exact wdata and be; cmem_rdata_b=0; both resps coincide.
- Captured fields: cmem_address_a changes to 0x64 during SERVE_A -> pmem_address stays 0x60 until pmem_resp.
- Reset asserted mid-SERVE_B, then pmem_resp pulses after deassert -> all outputs 0 immediately; FSM stays IDLE with no cmem_resp until a new request.
- With CMEM_RESPONDER_PERF_EN: 5 dual-port transactions -> perf_a_count=5, perf_b_count=5. Without the macro -> both read 0.

Source files
------------

// File: rtl/cmem_responder.sv
`timescale 1ns/1ps
// cmem_responder
//   Memory-side responder for the CPU's two cmem ports: a (instruction fetch)
//   and b (data). Both pending requests are captured together, served one at
//   a time on pmem (b first, then a), and completed with a single shared resp
//   cycle so the CPU pipeline can advance on both ports at once.
//   Optional feature: define CMEM_RESPONDER_PERF_EN to get per-port completion
//   counters on perf_a_count / perf_b_count (tied to 0 otherwise).
module cmem_responder #(
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // port a (fetch)
    input  logic                  cmem_read_a,
    input  logic                  cmem_write_a,
    input  logic [3:0]            cmem_byte_enable_a,
    input  logic [31:0]           cmem_address_a,
    input  logic [31:0]           cmem_wdata_a,
    output logic                  cmem_resp_a,
    output logic [31:0]           cmem_rdata_a,
    // port b (data)
    input  logic                  cmem_read_b,
    input  logic                  cmem_write_b,
    input  logic [3:0]            cmem_byte_enable_b,
    input  logic [31:0]           cmem_address_b,
    input  logic [31:0]           cmem_wdata_b,
    output logic                  cmem_resp_b,
    output logic [31:0]           cmem_rdata_b,
    // physical memory
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [3:0]            pmem_byte_enable,
    output logic [31:0]           pmem_address,
    output logic [31:0]           pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [31:0]           pmem_rdata,
    // completion counters
    output logic [PERF_WIDTH-1:0] perf_a_count,
    output logic [PERF_WIDTH-1:0] perf_b_count
);

    typedef enum logic [1:0] {IDLE, SERVE_B, SERVE_A, RESP} state_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state;
    logic        mask_a;
    logic        mask_b;
    req_t        cap_a;     // port a request held while port b is served
    req_t        pm;        // request currently presented on pmem (0 when not serving)
    logic [31:0] buf_a;
    logic [31:0] buf_b;

    logic        req_a;
    logic        req_b;
    req_t        live_a;
    req_t        live_b;

    assign req_a  = cmem_read_a | cmem_write_a;
    assign req_b  = cmem_read_b | cmem_write_b;
    assign live_a = '{read: cmem_read_a, write: cmem_write_a, be: cmem_byte_enable_a,
                      addr: cmem_address_a, wdata: cmem_wdata_a};
    assign live_b = '{read: cmem_read_b, write: cmem_write_b, be: cmem_byte_enable_b,
                      addr: cmem_address_b, wdata: cmem_wdata_b};

    // pmem pins come straight from the pm register; read+write collapses to write
    assign pmem_read        = pm.read & ~pm.write;
    assign pmem_write       = pm.write;
    assign pmem_byte_enable = pm.be;
    assign pmem_address     = pm.addr;
    assign pmem_wdata       = pm.wdata;

    assign cmem_rdata_a = buf_a;
    assign cmem_rdata_b = buf_b;

    // Capture / serve b / serve a / joint resp sequencer with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mask_a      <= 1'b0;
            mask_b      <= 1'b0;
            cap_a       <= '0;
            pm          <= '0;
            buf_a       <= '0;
            buf_b       <= '0;
            cmem_resp_a <= 1'b0;
            cmem_resp_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        mask_a <= req_a;
                        mask_b <= req_b;
                        cap_a  <= live_a;
                        // b goes straight onto pmem; a waits in cap_a if b is pending
                        pm     <= req_b ? live_b : live_a;
                        state  <= req_b ? SERVE_B : SERVE_A;
                    end
                end
                SERVE_B: begin
                    if (pmem_resp) begin
                        buf_b <= pm.write ? 32'h0 : pmem_rdata;
                        if (mask_a) begin
                            // strobe stays high; only the fields switch to port a
                            pm    <= cap_a;
                            state <= SERVE_A;
                        end else begin
                            pm          <= '0;
                            cmem_resp_b <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                SERVE_A: begin
                    if (pmem_resp) begin
                        buf_a       <= pm.write ? 32'h0 : pmem_rdata;
                        pm          <= '0;
                        cmem_resp_a <= 1'b1;
                        cmem_resp_b <= mask_b;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    // one IDLE cycle follows so the CPU can retire its requests
                    cmem_resp_a <= 1'b0;
                    cmem_resp_b <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CMEM_RESPONDER_PERF_EN
    // Count completions per port; resp is only ever high during RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_a_count <= '0;
            perf_b_count <= '0;
        end else begin
            if (cmem_resp_a) perf_a_count <= perf_a_count + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
            if (cmem_resp_b) perf_b_count <= perf_b_count + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
        end
    end
`else
    assign perf_a_count = '0;
    assign perf_b_count = '0;
`endif

endmodule

// File: tb/tb_cmem_responder.sv
`timescale 1ns/1ps
// Bench for cmem_responder: directed vector table, randomized transactions
// scored against a transaction-level model, and a mid-transaction reset case.
module tb_cmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmem_read_a, cmem_write_a, cmem_read_b, cmem_write_b;
    logic [3:0]  cmem_byte_enable_a, cmem_byte_enable_b;
    logic [31:0] cmem_address_a, cmem_wdata_a, cmem_address_b, cmem_wdata_b;
    logic        cmem_resp_a, cmem_resp_b;
    logic [31:0] cmem_rdata_a, cmem_rdata_b;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
    logic [31:0] perf_a_count, perf_b_count;

    cmem_responder #(.PERF_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .cmem_read_a(cmem_read_a), .cmem_write_a(cmem_write_a),
        .cmem_byte_enable_a(cmem_byte_enable_a), .cmem_address_a(cmem_address_a),
        .cmem_wdata_a(cmem_wdata_a), .cmem_resp_a(cmem_resp_a), .cmem_rdata_a(cmem_rdata_a),
        .cmem_read_b(cmem_read_b), .cmem_write_b(cmem_write_b),
        .cmem_byte_enable_b(cmem_byte_enable_b), .cmem_address_b(cmem_address_b),
        .cmem_wdata_b(cmem_wdata_b), .cmem_resp_b(cmem_resp_b), .cmem_rdata_b(cmem_rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .perf_a_count(perf_a_count), .perf_b_count(perf_b_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ra, wa;
        logic [3:0]  bea;
        logic [31:0] aa, wda;
        logic        rb, wb;
        logic [3:0]  beb;
        logic [31:0] ab, wdb;
        int          lat_a, lat_b;    // strobe cycles per access, including the resp cycle
        int          exp_cyc;         // negedge index (after request) where cmem_resp shows
        logic [31:0] exp_rd_a, exp_rd_b;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
    } acc_t;

    int checks = 0;
    int errors = 0;
    int n_a = 0;
    int n_b = 0;

    // Memory contents as seen by reads
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h60) ? 32'h13 : ((a * 32'h9E37_79B1) ^ 32'h73);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmem_read_a = 0; cmem_write_a = 0; cmem_byte_enable_a = 0; cmem_address_a = 0; cmem_wdata_a = 0;
        cmem_read_b = 0; cmem_write_b = 0; cmem_byte_enable_b = 0; cmem_address_b = 0; cmem_wdata_b = 0;
        pmem_resp = 0; pmem_rdata = 0;
    endtask

    // Called just after a negedge with the DUT in IDLE. Acts as pmem, scrambles
    // cmem fields after capture, and scores the whole transaction.
    task automatic run_txn(input vec_t v, input string tag);
        acc_t q[$];
        acc_t cur;
        bit   have_cur = 0;
        bit   done = 0;
        int   waited = 0;
        int   strobes = 0;
        int   resp_k = 0;
        logic req_a = v.ra | v.wa;
        logic req_b = v.rb | v.wb;
        if (req_b) q.push_back('{v.ab, v.wb, v.beb, v.wdb, v.lat_b});
        if (req_a) q.push_back('{v.aa, v.wa, v.bea, v.wda, v.lat_a});
        cmem_read_a = v.ra; cmem_write_a = v.wa; cmem_byte_enable_a = v.bea;
        cmem_address_a = v.aa; cmem_wdata_a = v.wda;
        cmem_read_b = v.rb; cmem_write_b = v.wb; cmem_byte_enable_b = v.beb;
        cmem_address_b = v.ab; cmem_wdata_b = v.wdb;
        pmem_resp = 0;
        for (int k = 1; k <= v.exp_cyc + 20 && !done; k++) begin
            @(negedge clk);
            pmem_resp = 0;
            // live fields move after capture; the DUT must keep the captured ones
            cmem_address_a = v.aa ^ 32'h4;  cmem_wdata_a = ~v.wda; cmem_byte_enable_a = ~v.bea;
            cmem_address_b = v.ab ^ 32'h8;  cmem_wdata_b = ~v.wdb; cmem_byte_enable_b = ~v.beb;
            if (cmem_resp_a || cmem_resp_b) begin
                resp_k = k;
                done = 1;
            end else if (pmem_read || pmem_write) begin
                strobes++;
                if (!have_cur) begin
                    if (q.size() == 0) begin
                        chk({tag, " extra pmem access"}, 1, 0);
                        cur = '{pmem_address, pmem_write, pmem_byte_enable, pmem_wdata, 1};
                    end else begin
                        cur = q.pop_front();
                    end
                    have_cur = 1;
                    waited = 0;
                end
                chk({tag, " pmem addr"}, pmem_address, cur.addr);
                chk({tag, " pmem write"}, 32'(pmem_write), 32'(cur.wr));
                chk({tag, " pmem read"}, 32'(pmem_read), 32'(!cur.wr));
                chk({tag, " pmem be"}, 32'(pmem_byte_enable), 32'(cur.be));
                chk({tag, " pmem wdata"}, pmem_wdata, cur.wdata);
                waited++;
                if (waited >= cur.lat) begin
                    pmem_resp = 1;
                    pmem_rdata = pmem_write ? $urandom() : mem_fn(pmem_address);
                    have_cur = 0;
                end
            end
        end
        idle_inputs();
        if (!done) begin
            chk({tag, " resp timeout"}, 0, 1);
        end else begin
            chk({tag, " resp cycle"}, resp_k, v.exp_cyc);
            chk({tag, " resp_a"}, 32'(cmem_resp_a), 32'(req_a));
            chk({tag, " resp_b"}, 32'(cmem_resp_b), 32'(req_b));
            if (req_a) chk({tag, " rdata_a"}, cmem_rdata_a, v.exp_rd_a);
            if (req_b) chk({tag, " rdata_b"}, cmem_rdata_b, v.exp_rd_b);
            chk({tag, " strobe cycles"}, strobes, v.exp_cyc - 1);
            chk({tag, " accesses left"}, q.size(), 0);
            @(negedge clk);
            chk({tag, " resp one cycle"}, {30'b0, cmem_resp_a, cmem_resp_b}, 0);
            chk({tag, " pmem idle"}, {30'b0, pmem_read, pmem_write}, 0);
        end
        n_a += int'(req_a);
        n_b += int'(req_b);
    endtask

    // Random transaction with model-derived expectations
    function automatic vec_t rand_vec(input bit both);
        vec_t v;
        int   sel = both ? 3 : $urandom_range(1, 3);
        int   op;
        v.aa = $urandom() & 32'hFFFF_FFFC; v.wda = $urandom(); v.bea = 4'($urandom());
        v.ab = $urandom() & 32'hFFFF_FFFC; v.wdb = $urandom(); v.beb = 4'($urandom());
        v.lat_a = $urandom_range(1, 4);    v.lat_b = $urandom_range(1, 4);
        op = $urandom_range(0, 2);
        v.ra = sel[0] && op != 1;  v.wa = sel[0] && op != 0;
        op = $urandom_range(0, 2);
        v.rb = sel[1] && op != 1;  v.wb = sel[1] && op != 0;
        v.exp_cyc  = 1 + (sel[0] ? v.lat_a : 0) + (sel[1] ? v.lat_b : 0);
        v.exp_rd_a = v.wa ? 32'h0 : mem_fn(v.aa);
        v.exp_rd_b = v.wb ? 32'h0 : mem_fn(v.ab);
        return v;
    endfunction

    vec_t tbl[6];
    int   any_bad;
    logic [31:0] exp_perf;

    initial begin
        //          ra wa bea      aa           wda           rb wb beb      ab           wdb           la lb cyc exp_rd_a      exp_rd_b
        tbl[0] = '{1, 0, 4'hF,   32'h60,  32'h0,         0, 0, 4'h0,   32'h0,   32'h0,         1, 1, 2, 32'h13,       32'h0};
        tbl[1] = '{1, 0, 4'hF,   32'h60,  32'h0,         1, 0, 4'hF,   32'h100, 32'h0,         3, 3, 7, 32'h13,       32'h3779B173};
        tbl[2] = '{1, 0, 4'hF,   32'h60,  32'h0,         0, 1, 4'b0011, 32'h200, 32'hDEADBEEF, 1, 1, 3, 32'h13,       32'h0};
        tbl[3] = '{0, 0, 4'h0,   32'h0,   32'h0,         1, 0, 4'hF,   32'h100, 32'h0,         1, 2, 3, 32'h0,        32'h3779B173};
        tbl[4] = '{1, 1, 4'hF,   32'h300, 32'h12345678,  0, 0, 4'h0,   32'h0,   32'h0,         2, 1, 3, 32'h0,        32'h0};
        tbl[5] = '{0, 1, 4'b1000, 32'h40, 32'hCAFEF00D,  1, 1, 4'h5,   32'h100, 32'h0A0B0C0D,  1, 4, 6, 32'h0,        32'h0};

        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        chk("reset outputs", {27'b0, cmem_resp_a, cmem_resp_b, pmem_read, pmem_write, |pmem_byte_enable}, 0);
        chk("reset pmem_address", pmem_address, 0);
        chk("reset rdata_a", cmem_rdata_a, 0);
        chk("reset perf_a", perf_a_count, 0);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 60; i++) run_txn(rand_vec(0), $sformatf("rnd%0d", i));

        // reset in the middle of SERVE_B, then a stray pmem_resp
        cmem_read_a = 1; cmem_address_a = 32'h60;
        cmem_read_b = 1; cmem_address_b = 32'h500; cmem_byte_enable_b = 4'hF;
        @(negedge clk);
        chk("midrst serve_b strobe", {pmem_read, pmem_address}, {1'b1, 32'h500});
        #2 reset = 1;
        #1;
        chk("midrst outputs", {25'b0, cmem_resp_a, cmem_resp_b, pmem_read, pmem_write, pmem_byte_enable}, 0);
        chk("midrst pmem_address", pmem_address, 0);
        chk("midrst rdata", cmem_rdata_a | cmem_rdata_b, 0);
        chk("midrst perf", perf_a_count | perf_b_count, 0);
        idle_inputs();
        @(negedge clk);
        reset = 0;
        n_a = 0; n_b = 0;
        pmem_resp = 1; pmem_rdata = 32'hBAD0BAD0;
        any_bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pmem_resp = 0;
            if (cmem_resp_a || cmem_resp_b || pmem_read || pmem_write) any_bad++;
        end
        chk("postrst stays idle", any_bad, 0);

        // five dual-port transactions from a clean counter state
        for (int i = 0; i < 5; i++) run_txn(rand_vec(1), $sformatf("dual%0d", i));
`ifdef CMEM_RESPONDER_PERF_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        chk("perf_a after 5 dual", perf_a_count, exp_perf);
        chk("perf_b after 5 dual", perf_b_count, exp_perf);

        for (int i = 0; i < 20; i++) run_txn(rand_vec(0), $sformatf("rndb%0d", i));
`ifdef CMEM_RESPONDER_PERF_EN
        chk("perf_a final", perf_a_count, n_a);
        chk("perf_b final", perf_b_count, n_b);
`else
        chk("perf_a final", perf_a_count, 0);
        chk("perf_b final", perf_b_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
